// File: rtl/snn_ff_pkg.sv
// Shared types and helpers for the FF-STDP spike-history blocks.
//
// Contents:
//   pre_arr_state_t : FSM state of pre_neuron_array (S_IDLE, S_CLEAR)
//   POPCOUNT_MAX_W  : widest bit vector the popcount helper accepts
//   popcount()      : number of set bits in a zero-extended vector
package snn_ff_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } pre_arr_state_t;

  // Callers zero-extend their vector to this width, so one function body
  // serves every history width up to this limit.
  localparam int unsigned POPCOUNT_MAX_W = 256;

  function automatic int unsigned popcount(input logic [POPCOUNT_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POPCOUNT_MAX_W; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/spike_popcount.sv
// Combinational popcount of one spike-history bitmap.
//
// Ports:
//   i_bits : TIME_STEP-bit spike bitmap
//   o_cnt  : number of set bits, 0..TIME_STEP
module spike_popcount
  import snn_ff_pkg::*;
#(
  parameter int TIME_STEP = 8,
  parameter int CNT_W     = $clog2(TIME_STEP + 1)
) (
  input  logic [TIME_STEP-1:0] i_bits,
  output logic [CNT_W-1:0]     o_cnt
);

  always_comb begin
    o_cnt = CNT_W'(popcount(POPCOUNT_MAX_W'(i_bits)));
  end

endmodule

// File: rtl/pre_neuron_array.sv
// Spike-history register file for N_PRE pre-synaptic neurons.
//
// Each neuron owns a TIME_STEP-bit bitmap; bit t is set when a spike event
// for that neuron arrives while current_time_step == t. A time-reference
// pulse starts a sweep that zeroes one entry per cycle. A 1-cycle readout
// port returns a bitmap and its popcount to the learning engine.
//
// Handshake: an event is transferred on a clock edge where evt_valid and
// evt_ready are both high; evt_ready depends only on registered state, and
// the producer may hold or drop evt_valid freely while evt_ready is low.
//
// Ports:
//   CLK, RST          : clock, synchronous active-high reset
//   current_time_step : step index applied to accepted events
//   evt_valid/addr    : spike event stream in; evt_ready out
//   time_ref_event    : pulse starting a clear sweep
//   clear_busy        : sweep in progress; clear_done pulses on its last cycle
//   rd_req/rd_addr    : readout request; rd_valid/rd_hist/rd_cnt one cycle later
//   ts_err            : sticky, an event arrived with an out-of-range step
//   dbg_state         : current FSM state
module pre_neuron_array
  import snn_ff_pkg::*;
#(
  parameter int N_PRE     = 256,
  parameter int TIME_STEP = 8,
  parameter int ADDR_W    = $clog2(N_PRE),
  parameter int TS_W      = $clog2(TIME_STEP),
  parameter int CNT_W     = $clog2(TIME_STEP + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [TS_W-1:0]      current_time_step,
  input  logic                 evt_valid,
  input  logic [ADDR_W-1:0]    evt_addr,
  output logic                 evt_ready,
  input  logic                 time_ref_event,
  output logic                 clear_busy,
  output logic                 clear_done,
  input  logic                 rd_req,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic                 rd_valid,
  output logic [TIME_STEP-1:0] rd_hist,
  output logic [CNT_W-1:0]     rd_cnt,
  output logic                 ts_err,
  output pre_arr_state_t       dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PRE - 1);

  pre_arr_state_t       r_state;
  pre_arr_state_t       w_state_nxt;
  logic [ADDR_W-1:0]    r_ptr;
  logic [ADDR_W-1:0]    w_ptr_nxt;
  logic [TIME_STEP-1:0] r_hist [N_PRE];

  logic                 r_evt_ready;
  logic                 r_ts_err;
  logic                 r_rd_valid;
  logic [TIME_STEP-1:0] r_rd_hist;
  logic [CNT_W-1:0]     r_rd_cnt;

  logic                 w_evt_fire;
  logic                 w_evt_addr_ok;
  logic                 w_rd_addr_ok;
  logic                 w_ts_ok;
  logic                 w_sweep_last;
  logic                 w_rd_fire;
  logic [TIME_STEP-1:0] w_set_mask;
  logic [TIME_STEP-1:0] w_rd_word;
  logic [CNT_W-1:0]     w_rd_word_cnt;

  // Range checks only exist when the index width can encode values past
  // the end of the array / window; otherwise they are constant true.
  generate
    if (N_PRE == (1 << ADDR_W)) begin : g_addr_full
      assign w_evt_addr_ok = 1'b1;
      assign w_rd_addr_ok  = 1'b1;
    end else begin : g_addr_part
      assign w_evt_addr_ok = (evt_addr <= LAST_ADDR);
      assign w_rd_addr_ok  = (rd_addr <= LAST_ADDR);
    end

    if (TIME_STEP == (1 << TS_W)) begin : g_ts_full
      assign w_ts_ok = 1'b1;
    end else begin : g_ts_part
      assign w_ts_ok = (current_time_step < TS_W'(TIME_STEP));
    end
  endgenerate

  // evt_ready is only ever high in IDLE, so it doubles as the IDLE gate.
  assign w_evt_fire   = evt_valid && r_evt_ready;
  assign w_rd_fire    = rd_req && (r_state == S_IDLE);
  assign w_sweep_last = (r_state == S_CLEAR) && (r_ptr == LAST_ADDR);

  always_comb begin
    w_set_mask = '0;
    for (int t = 0; t < TIME_STEP; t++) begin
      w_set_mask[t] = (current_time_step == TS_W'(t));
    end
  end

  always_comb begin
    w_rd_word = '0;
    if (w_rd_addr_ok) begin
      w_rd_word = r_hist[rd_addr];
    end
  end

  spike_popcount #(
    .TIME_STEP (TIME_STEP),
    .CNT_W     (CNT_W)
  ) u_popcount (
    .i_bits (w_rd_word),
    .o_cnt  (w_rd_word_cnt)
  );

  // FSM next state. time_ref_event is only looked at in IDLE, so a pulse
  // arriving mid-sweep neither restarts nor extends the sweep.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (time_ref_event) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      S_CLEAR: begin
        if (w_sweep_last) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + ADDR_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_evt_ready <= 1'b0;
      r_ts_err    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_hist   <= '0;
      r_rd_cnt    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_evt_ready <= (w_state_nxt == S_IDLE);
      if (w_evt_fire && !w_ts_ok) begin
        r_ts_err <= 1'b1;
      end
      r_rd_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_hist <= w_rd_word;
        r_rd_cnt  <= w_rd_word_cnt;
      end
    end
  end

  // Register file. The read above samples r_hist before this edge updates
  // it, so a same-cycle read of a written entry returns the old bitmap.
  // Writes happen only in IDLE and sweep clears only in CLEAR, so the two
  // never compete for an entry.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N_PRE; i++) begin
        r_hist[i] <= '0;
      end
    end else if (r_state == S_CLEAR) begin
      r_hist[r_ptr] <= '0;
    end else if (w_evt_fire && w_evt_addr_ok && w_ts_ok) begin
      r_hist[evt_addr] <= r_hist[evt_addr] | w_set_mask;
    end
  end

  assign evt_ready  = r_evt_ready;
  assign clear_busy = (r_state == S_CLEAR);
  assign clear_done = w_sweep_last;
  assign rd_valid   = r_rd_valid;
  assign rd_hist    = r_rd_hist;
  assign rd_cnt     = r_rd_cnt;
  assign ts_err     = r_ts_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_pre_neuron_array.sv
// Testbench for pre_neuron_array. Instance u_dut_a (16 neurons, 8 steps)
// carries the scoreboarded readout tests; u_dut_b (4 neurons, 6 steps)
// covers the out-of-range step flag and reset during a sweep.
module tb_pre_neuron_array;
  import snn_ff_pkg::*;

  localparam int NA     = 16;
  localparam int TSA    = 8;
  localparam int AW_A   = 4;
  localparam int TW_A   = 3;
  localparam int CW_A   = 4;
  localparam int QW     = TSA + CW_A;

  localparam int NB     = 4;
  localparam int TSB    = 6;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic rst_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT A ----------------
  logic [TW_A-1:0] cts_a;
  logic            evt_valid_a;
  logic [AW_A-1:0] evt_addr_a;
  logic            evt_ready_a;
  logic            tref_a;
  logic            busy_a;
  logic            done_a;
  logic            rd_req_a;
  logic [AW_A-1:0] rd_addr_a;
  logic            rd_valid_a;
  logic [TSA-1:0]  rd_hist_a;
  logic [CW_A-1:0] rd_cnt_a;
  logic            ts_err_a;
  pre_arr_state_t  dbg_a;

  pre_neuron_array #(.N_PRE(NA), .TIME_STEP(TSA)) u_dut_a (
    .CLK               (clk),
    .RST               (rst),
    .current_time_step (cts_a),
    .evt_valid         (evt_valid_a),
    .evt_addr          (evt_addr_a),
    .evt_ready         (evt_ready_a),
    .time_ref_event    (tref_a),
    .clear_busy        (busy_a),
    .clear_done        (done_a),
    .rd_req            (rd_req_a),
    .rd_addr           (rd_addr_a),
    .rd_valid          (rd_valid_a),
    .rd_hist           (rd_hist_a),
    .rd_cnt            (rd_cnt_a),
    .ts_err            (ts_err_a),
    .dbg_state         (dbg_a)
  );

  // ---------------- DUT B ----------------
  logic [2:0]     cts_b;
  logic           evt_valid_b;
  logic [1:0]     evt_addr_b;
  logic           evt_ready_b;
  logic           tref_b;
  logic           busy_b;
  logic           done_b;
  logic           rd_req_b;
  logic [1:0]     rd_addr_b;
  logic           rd_valid_b;
  logic [TSB-1:0] rd_hist_b;
  logic [2:0]     rd_cnt_b;
  logic           ts_err_b;
  pre_arr_state_t dbg_b;

  pre_neuron_array #(.N_PRE(NB), .TIME_STEP(TSB)) u_dut_b (
    .CLK               (clk),
    .RST               (rst_b),
    .current_time_step (cts_b),
    .evt_valid         (evt_valid_b),
    .evt_addr          (evt_addr_b),
    .evt_ready         (evt_ready_b),
    .time_ref_event    (tref_b),
    .clear_busy        (busy_b),
    .clear_done        (done_b),
    .rd_req            (rd_req_b),
    .rd_addr           (rd_addr_b),
    .rd_valid          (rd_valid_b),
    .rd_hist           (rd_hist_b),
    .rd_cnt            (rd_cnt_b),
    .ts_err            (ts_err_b),
    .dbg_state         (dbg_b)
  );

  // ---------------- checking / scoreboard ----------------
  int n_checks;
  int n_fail;
  logic [QW-1:0]  exp_q[$];
  logic [TSA-1:0] model_a [NA];
  logic [TSA-1:0] last_pushed_hist;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Readout monitor for DUT A: every rd_valid must match the oldest
  // expected entry.
  always @(negedge clk) begin
    if (rd_valid_a === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 32'(rd_valid_a), 32'd0);
      end else begin
        logic [QW-1:0] e;
        e = exp_q.pop_front();
        check("rd_hist", 32'(rd_hist_a), 32'(e[QW-1:CW_A]));
        check("rd_cnt", 32'(rd_cnt_a), 32'(e[CW_A-1:0]));
      end
    end
  end

  // ---------------- driver tasks (DUT A) ----------------
  // Called just after a falling edge; drives one cycle and returns just
  // after the next falling edge with all strobes deasserted.
  task automatic drive_cycle(input logic ev, input int ea, input int ets,
                             input logic rd, input int ra, input logic tref);
    if (ev) check("evt_ready_idle", 32'(evt_ready_a), 32'd1);
    if (rd) begin
      exp_q.push_back({model_a[ra], CW_A'($countones(model_a[ra]))});
      last_pushed_hist = model_a[ra];
    end
    if (ev && ets < TSA) model_a[ea] = model_a[ea] | TSA'(1 << ets);
    if (tref) begin
      for (int i = 0; i < NA; i++) model_a[i] = '0;
    end
    evt_valid_a = ev;
    evt_addr_a  = AW_A'(ea);
    cts_a       = TW_A'(ets);
    rd_req_a    = rd;
    rd_addr_a   = AW_A'(ra);
    tref_a      = tref;
    @(negedge clk);
    evt_valid_a = 1'b0;
    rd_req_a    = 1'b0;
    tref_a      = 1'b0;
  endtask

  task automatic send_evt(input int ea, input int ets);
    drive_cycle(1'b1, ea, ets, 1'b0, 0, 1'b0);
  endtask

  task automatic read_a(input int ra);
    drive_cycle(1'b0, 0, 0, 1'b1, ra, 1'b0);
  endtask

  task automatic drain;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic read_all_zero;
    for (int a = 0; a < NA; a++) read_a(a);
    drain();
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_ready"}, 32'(evt_ready_a), 32'd0);
    check({tag, "_busy"},  32'(busy_a), 32'd0);
    check({tag, "_done"},  32'(done_a), 32'd0);
    check({tag, "_valid"}, 32'(rd_valid_a), 32'd0);
    check({tag, "_hist"},  32'(rd_hist_a), 32'd0);
    check({tag, "_cnt"},   32'(rd_cnt_a), 32'd0);
    check({tag, "_tserr"}, 32'(ts_err_a), 32'd0);
  endtask

  // Entered one falling edge after the tref cycle. Also pokes an event and
  // a read mid-sweep (both must be ignored) and optionally a second tref.
  task automatic sweep_check(input logic retrig);
    for (int i = 0; i < NA; i++) begin
      check("sweep_busy", 32'(busy_a), 32'd1);
      check("sweep_done", 32'(done_a), 32'(i == NA - 1));
      check("sweep_ready", 32'(evt_ready_a), 32'd0);
      check("sweep_state", 32'(dbg_a), 32'(S_CLEAR));
      if (i == 3) begin
        evt_valid_a = 1'b1;
        evt_addr_a  = AW_A'(7);
        cts_a       = TW_A'(1);
        rd_req_a    = 1'b1;
        rd_addr_a   = AW_A'(5);
      end
      if (retrig && i == 5) tref_a = 1'b1;
      @(negedge clk);
      evt_valid_a = 1'b0;
      rd_req_a    = 1'b0;
      tref_a      = 1'b0;
    end
    check("sweep_end_busy", 32'(busy_a), 32'd0);
    check("sweep_end_done", 32'(done_a), 32'd0);
    check("sweep_end_ready", 32'(evt_ready_a), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    last_pushed_hist = '0;
    for (int i = 0; i < NA; i++) model_a[i] = '0;
    rst = 1'b1; rst_b = 1'b1;
    cts_a = '0; evt_valid_a = 1'b0; evt_addr_a = '0; tref_a = 1'b0;
    rd_req_a = 1'b0; rd_addr_a = '0;
    cts_b = '0; evt_valid_b = 1'b0; evt_addr_b = '0; tref_b = 1'b0;
    rd_req_b = 1'b0; rd_addr_b = '0;

    repeat (3) @(negedge clk);
    check_reset_a("rst");
    rst = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(evt_ready_a), 32'd1);
    check("post_rst_state", 32'(dbg_a), 32'(S_IDLE));

    // Steps 0, 3, 7 on neuron 5 -> 0x89, count 3.
    send_evt(5, 0); send_evt(5, 3); send_evt(5, 7);
    read_a(5);
    // Repeated event is idempotent: 0x04, count 1.
    send_evt(9, 2); send_evt(9, 2);
    read_a(9);
    // Read-before-write on neuron 4.
    send_evt(4, 0);
    drive_cycle(1'b1, 4, 1, 1'b1, 4, 1'b0);
    read_a(4);
    drain();

    // Random traffic with same-cycle reads.
    for (int i = 0; i < 24; i++) begin
      drive_cycle(1'b1, $urandom_range(0, NA - 1), $urandom_range(0, TSA - 1),
                  1'($urandom_range(0, 1)), $urandom_range(0, NA - 1), 1'b0);
    end
    for (int a = 0; a < NA; a++) read_a(a);
    read_a(5);
    drain();

    // Full sweep; readout registers must hold across it.
    drive_cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
    sweep_check(1'b0);
    check("rd_hist_hold", 32'(rd_hist_a), 32'(last_pushed_hist));
    check("rd_valid_idle", 32'(rd_valid_a), 32'd0);
    read_all_zero();

    // Event coincident with tref, plus a mid-sweep retrigger.
    send_evt(3, 6); send_evt(11, 2);
    drive_cycle(1'b1, 3, 4, 1'b0, 0, 1'b1);
    sweep_check(1'b1);
    read_all_zero();

    // Reset in the middle of a sweep.
    send_evt(2, 1); send_evt(12, 5);
    drive_cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < NA; i++) model_a[i] = '0;
    @(negedge clk);
    check_reset_a("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 32'(evt_ready_a), 32'd1);
    read_all_zero();

    // ---------------- DUT B: TIME_STEP = 6 ----------------
    check("b_tserr_init", 32'(ts_err_b), 32'd0);
    evt_valid_b = 1'b1; evt_addr_b = 2'd1; cts_b = 3'd7;
    @(negedge clk);
    evt_valid_b = 1'b0;
    check("b_tserr_set", 32'(ts_err_b), 32'd1);
    rd_req_b = 1'b1; rd_addr_b = 2'd1;
    @(negedge clk);
    rd_req_b = 1'b0;
    check("b_oor_valid", 32'(rd_valid_b), 32'd1);
    check("b_oor_hist", 32'(rd_hist_b), 32'd0);
    check("b_oor_cnt", 32'(rd_cnt_b), 32'd0);
    evt_valid_b = 1'b1; evt_addr_b = 2'd1; cts_b = 3'd5;
    @(negedge clk);
    evt_valid_b = 1'b0;
    rd_req_b = 1'b1; rd_addr_b = 2'd1;
    @(negedge clk);
    rd_req_b = 1'b0;
    check("b_top_hist", 32'(rd_hist_b), 32'h20);
    check("b_top_cnt", 32'(rd_cnt_b), 32'd1);
    check("b_tserr_sticky", 32'(ts_err_b), 32'd1);
    tref_b = 1'b1;
    @(negedge clk);
    tref_b = 1'b0;
    @(negedge clk);
    check("b_busy", 32'(busy_b), 32'd1);
    check("b_state", 32'(dbg_b), 32'(S_CLEAR));
    rst_b = 1'b1;
    @(negedge clk);
    check("b_rst_busy", 32'(busy_b), 32'd0);
    check("b_rst_done", 32'(done_b), 32'd0);
    check("b_rst_ready", 32'(evt_ready_b), 32'd0);
    check("b_rst_valid", 32'(rd_valid_b), 32'd0);
    check("b_rst_hist", 32'(rd_hist_b), 32'd0);
    check("b_rst_cnt", 32'(rd_cnt_b), 32'd0);
    check("b_rst_tserr", 32'(ts_err_b), 32'd0);
    rst_b = 1'b0;
    @(negedge clk);
    check("b_post_ready", 32'(evt_ready_b), 32'd1);
    rd_req_b = 1'b1; rd_addr_b = 2'd1;
    @(negedge clk);
    rd_req_b = 1'b0;
    check("b_post_valid", 32'(rd_valid_b), 32'd1);
    check("b_post_hist", 32'(rd_hist_b), 32'd0);

    repeat (2) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
